// File: rtl/maze_pkg.sv
// Shared constants and types for the 16x16 maze store.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the maze geometry, the restore FSM state encoding and the cell
// encoding used by the base and work bit planes.
package maze_pkg;

    // Maze geometry: the maze is N x N cells, coordinates are COORD_W bits.
    localparam int N       = 16;
    localparam int COORD_W = $clog2(N);

    // Restore FSM state encoding.
    typedef logic [0:0] state_t;
    localparam state_t IDLE    = 1'b0;
    localparam state_t RESTORE = 1'b1;

    // Cell encoding: a set bit is a wall or a cell the rat has marked.
    localparam logic CELL_FREE    = 1'b0;
    localparam logic CELL_BLOCKED = 1'b1;

endpackage

// File: rtl/maze_bit_plane.sv
// One N x N bit plane: row write, single-bit write, combinational row read.
// Latency: writes land on the next rising edge; the read is combinational.
// Backpressure: none; every write strobe is applied in the cycle it is seen.
//
// Ports:
//   clk, rst               clock and synchronous active-high clear (all cells free)
//   row_we/row_waddr/row_wdata   whole-row write
//   bit_we/bit_x/bit_y/bit_din   single-cell write at (bit_x, bit_y)
//   rd_row / rd_data       combinational read of one row; bit i = column i
//
// A row write wins over a bit write in the same cycle. The owner of the
// plane never asks for both at once, but the order is fixed so the result
// is deterministic regardless.
module maze_bit_plane #(
    parameter int N = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 row_we,
    input  logic [$clog2(N)-1:0] row_waddr,
    input  logic [N-1:0]         row_wdata,
    input  logic                 bit_we,
    input  logic [$clog2(N)-1:0] bit_x,
    input  logic [$clog2(N)-1:0] bit_y,
    input  logic                 bit_din,
    input  logic [$clog2(N)-1:0] rd_row,
    output logic [N-1:0]         rd_data
);
    import maze_pkg::*;

    logic [N-1:0] mem [N];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                mem[i] <= {N{CELL_FREE}};
            end
        end else if (row_we) begin
            mem[row_waddr] <= row_wdata;
        end else if (bit_we) begin
            mem[bit_y][bit_x] <= bit_din;
        end
    end

    assign rd_data = mem[rd_row];

endmodule

// File: rtl/maze_memory.sv
// Bit-mapped maze store with a pristine base plane and a rat-marked work plane.
// Latency: rd -> dout 1 cycle; rst_map -> 16 busy cycles (one row copied per cycle).
// Backpressure: none; rd/wr/ld_en/rst_map arriving while busy are dropped, not stalled.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset (both planes cleared)
//   x, y, rd, wr, din   rat access port; cell (x,y) is bit x of row y
//   dout                registered read data, holds when rd is low or dropped
//   rst_map             one-cycle pulse: copy base plane back into work plane
//   ld_en/ld_row/ld_data  maze loader, writes one row into both planes
//   busy                high while a restore is running
module maze_memory #(
    parameter int N = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [$clog2(N)-1:0] x,
    input  logic [$clog2(N)-1:0] y,
    input  logic                 rd,
    input  logic                 wr,
    input  logic                 din,
    output logic                 dout,
    input  logic                 rst_map,
    input  logic                 ld_en,
    input  logic [$clog2(N)-1:0] ld_row,
    input  logic [N-1:0]         ld_data,
    output logic                 busy
);
    import maze_pkg::*;

    localparam int CW = $clog2(N);

    state_t         state;
    logic [CW-1:0]  rc;

    logic           restoring;
    logic           load_go;
    logic           access_go;

    logic [N-1:0]   base_row;
    logic [N-1:0]   work_row;

    logic           work_row_we;
    logic [CW-1:0]  work_row_waddr;
    logic [N-1:0]   work_row_wdata;

    // Per-cycle arbitration: restore beats the loader, the loader beats the
    // rat port. rst is handled inside each register block and wins over all.
    assign restoring = (state == RESTORE);
    assign load_go   = (state == IDLE) && ld_en;
    assign access_go = (state == IDLE) && !ld_en;
    assign busy      = restoring;

    // The work plane's row-write port is shared by the restore copy and the
    // loader; they are mutually exclusive by the arbitration above.
    assign work_row_we    = restoring || load_go;
    assign work_row_waddr = restoring ? rc       : ld_row;
    assign work_row_wdata = restoring ? base_row : ld_data;

    // Base plane: only ever written by the loader. Its read port is steered
    // by the restore row counter.
    maze_bit_plane #(
        .N (N)
    ) u_base (
        .clk       (clk),
        .rst       (rst),
        .row_we    (load_go),
        .row_waddr (ld_row),
        .row_wdata (ld_data),
        .bit_we    (1'b0),
        .bit_x     ('0),
        .bit_y     ('0),
        .bit_din   (CELL_FREE),
        .rd_row    (rc),
        .rd_data   (base_row)
    );

    // Work plane: loader/restore row writes plus rat single-bit writes. Its
    // read port follows the rat's row so dout is a simple column select.
    maze_bit_plane #(
        .N (N)
    ) u_work (
        .clk       (clk),
        .rst       (rst),
        .row_we    (work_row_we),
        .row_waddr (work_row_waddr),
        .row_wdata (work_row_wdata),
        .bit_we    (access_go && wr),
        .bit_x     (x),
        .bit_y     (y),
        .bit_din   (din),
        .rd_row    (y),
        .rd_data   (work_row)
    );

    // Restore FSM. rst_map seen while already restoring is ignored, so a
    // restore always runs exactly N cycles from the pulse that started it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rc    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rst_map) begin
                        state <= RESTORE;
                        rc    <= '0;
                    end
                end
                RESTORE: begin
                    // rc wraps back to 0 after the last row.
                    rc <= rc + 1'b1;
                    if (rc == CW'(N - 1)) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    rc    <= '0;
                end
            endcase
        end
    end

    // Read data register. The work plane read is taken before the same-edge
    // bit write lands, which gives read-before-write on a shared cell.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= CELL_FREE;
        end else if (access_go && rd) begin
            dout <= work_row[x];
        end
    end

endmodule

// File: tb/tb_maze_memory.sv
module tb_maze_memory;

    logic        clk;
    logic        rst;
    logic [3:0]  x;
    logic [3:0]  y;
    logic        rd;
    logic        wr;
    logic        din;
    logic        dout;
    logic        rst_map;
    logic        ld_en;
    logic [3:0]  ld_row;
    logic [15:0] ld_data;
    logic        busy;

    int passed = 0;
    int total  = 0;

    logic  exp_q  [$];
    string name_q [$];
    logic  rd_seen;

    maze_memory #(.N(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .x       (x),
        .y       (y),
        .rd      (rd),
        .wr      (wr),
        .din     (din),
        .dout    (dout),
        .rst_map (rst_map),
        .ld_en   (ld_en),
        .ld_row  (ld_row),
        .ld_data (ld_data),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Monitor: a read strobe sampled at a rising edge presents dout by the
    // following falling edge; compare it against the oldest expectation.
    always @(posedge clk) rd_seen <= rd && !rst;

    always @(negedge clk) begin
        if (rd_seen) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_underrun", 32'd1, 32'd0);
            end else begin
                logic  e;
                string n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check(n, {31'd0, dout}, {31'd0, e});
            end
        end
    end

    task automatic drive_idle();
        rst = 0; rd = 0; wr = 0; din = 0; rst_map = 0; ld_en = 0;
        ld_row = 0; ld_data = 0;
    endtask

    task automatic expect_read(input int cx, input int cy, input logic e, input string nm);
        rd = 1; x = 4'(cx); y = 4'(cy);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic rd_cell(input int cx, input int cy, input logic e, input string nm);
        @(negedge clk);
        drive_idle();
        expect_read(cx, cy, e, nm);
    endtask

    task automatic wr_cell(input int cx, input int cy, input logic d);
        @(negedge clk);
        drive_idle();
        wr = 1; din = d; x = 4'(cx); y = 4'(cy);
    endtask

    task automatic load_row(input int r, input logic [15:0] data);
        @(negedge clk);
        drive_idle();
        ld_en = 1; ld_row = 4'(r); ld_data = data;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        drive_idle();
    endtask

    task automatic read_all_zero(input string tag);
        for (int cy = 0; cy < 16; cy++)
            for (int cx = 0; cx < 16; cx++)
                rd_cell(cx, cy, 1'b0, $sformatf("%s(%0d,%0d)", tag, cx, cy));
        idle_cycle();
    endtask

    // Pulse rst_map, then count falling edges with busy high (bounded).
    // mode 0: rd/wr/ld_en issued while busy; mode 1: repeated rst_map;
    // mode 2: rst on the 5th busy cycle.
    task automatic run_restore(input int mode, output int cnt);
        @(negedge clk);
        drive_idle();
        rst_map = 1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            drive_idle();
            if (!busy) break;
            cnt++;
            case (mode)
                0: begin
                    if (i == 2) expect_read(4, 2, 1'b1, "rd_dropped_dout_holds");
                    if (i == 4) begin wr = 1; din = 1; x = 0; y = 0; end
                    if (i == 6) begin ld_en = 1; ld_row = 4'd1; ld_data = 16'hFFFF; end
                end
                1: if (i == 3 || i == 10 || i == 15) rst_map = 1;
                2: if (i == 4) rst = 1;
                default: ;
            endcase
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        x = 0; y = 0;
        drive_idle();
        rst = 1;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_dout", {31'd0, dout}, 32'd0);
        drive_idle();

        // Every cell free after reset; (0,0) is the first read.
        read_all_zero("reset_cell");

        // Load row 3 with a single wall at column 4.
        load_row(3, 16'h0010);
        rd_cell(4, 3, 1'b1, "load_4_3");
        rd_cell(5, 3, 1'b0, "load_5_3");
        rd_cell(4, 2, 1'b0, "load_4_2");

        // Read-before-write on the same cell, then the new value.
        @(negedge clk);
        drive_idle();
        wr = 1; din = 1;
        expect_read(5, 3, 1'b0, "rbw_old_5_3");
        rd_cell(5, 3, 1'b1, "rbw_new_5_3");

        // dout holds while rd is low.
        rd_cell(4, 3, 1'b1, "hold_setup_4_3");
        idle_cycle();
        idle_cycle();
        check("dout_hold", {31'd0, dout}, 32'd1);

        // Mark (7,7), then restore with dropped accesses while busy.
        wr_cell(7, 7, 1'b1);
        rd_cell(7, 7, 1'b1, "mark_7_7");
        run_restore(0, cnt);
        check("restore_busy_cycles", cnt, 32'd16);
        rd_cell(7, 7, 1'b0, "restored_7_7");
        rd_cell(4, 3, 1'b1, "base_kept_4_3");
        rd_cell(5, 3, 1'b0, "restored_5_3");
        rd_cell(0, 0, 1'b0, "dropped_wr_0_0");
        rd_cell(0, 1, 1'b0, "dropped_ld_0_1");
        rd_cell(15, 1, 1'b0, "dropped_ld_15_1");

        // Repeated rst_map during busy must not extend the restore.
        wr_cell(9, 8, 1'b1);
        run_restore(1, cnt);
        check("restart_ignored_cycles", cnt, 32'd16);
        rd_cell(9, 8, 1'b0, "restored_9_8");
        rd_cell(4, 3, 1'b1, "base_kept2_4_3");

        // rst on the 5th busy cycle aborts the restore and clears everything.
        rd_cell(4, 3, 1'b1, "pre_abort_4_3");
        run_restore(2, cnt);
        check("abort_busy_cycles", cnt, 32'd5);
        check("abort_dout", {31'd0, dout}, 32'd0);
        read_all_zero("abort_cell");

        idle_cycle();
        idle_cycle();
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
